lsu_mem_ctrl: RTL

- Load/store initiator that drives the byte-lane data memory on behalf of the core's MEM stage.
- Accepts one load or store per request handshake; the request carries size (byte/half/word) and a signedness flag.
- Generates the lane enable mask, write strobe and unrotated write data for the memory.
- Realigns the returned lane data by the byte offset, sign- or zero-extends it, and returns it on a response handshake.
- Owns the memory's one-cycle read latency, so the core never sees lane order.

---
 rtl/lsu_pkg.sv | 72 +++++++
 rtl/lsu_load_align.sv | 54 +++++
 rtl/lsu_mem_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit memory controller.
//   size_e  : access size encoding carried on req_size
//   state_e : controller FSM states
//   MASK_*  : unrotated bank-enable masks per access size
//   rotl4, base_mask, keep_bytes, is_misaligned : small combinational helpers
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_BAD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } state_e;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Rotate a 4-bit bank mask left by n lanes (bank 3 wraps to bank 0).
  function automatic logic [3:0] rotl4(input logic [3:0] m, input logic [1:0] n);
    logic [3:0] r;
    case (n)
      2'd0:    r = m;
      2'd1:    r = {m[2:0], m[3]};
      2'd2:    r = {m[1:0], m[3:2]};
      2'd3:    r = {m[0], m[3:1]};
      default: r = m;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] base_mask(input size_e sz);
    logic [3:0] r;
    case (sz)
      SZ_B:    r = MASK_B;
      SZ_H:    r = MASK_H;
      SZ_W:    r = MASK_W;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Zero the store-data bytes above the access size.
  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input size_e sz);
    logic [31:0] r;
    case (sz)
      SZ_B:    r = {24'h000000, d[7:0]};
      SZ_H:    r = {16'h0000, d[15:0]};
      SZ_W:    r = d;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    logic r;
    case (sz)
      SZ_H:    r = off[0];
      SZ_W:    r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: turns raw bank data into the core's load value.
//   mem_dout    : {bank3,bank2,bank1,bank0} as returned by the memory
//   off         : byte offset of the access (addr[1:0])
//   size        : access size
//   is_unsigned : 1 = zero-extend, 0 = sign-extend (byte/half only)
//   data        : realigned, extended load value (0 for an illegal size)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_dout,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] rot_s;

  // Rotate right by 8*off so logical byte k comes from bank (k+off)%4.
  always_comb begin
    rot_s = mem_dout;
    case (off)
      2'd0:    rot_s = mem_dout;
      2'd1:    rot_s = {mem_dout[7:0],  mem_dout[31:8]};
      2'd2:    rot_s = {mem_dout[15:0], mem_dout[31:16]};
      2'd3:    rot_s = {mem_dout[23:0], mem_dout[31:24]};
      default: rot_s = mem_dout;
    endcase
  end

  // Sign- or zero-extend the low bytes according to size.
  always_comb begin
    data = 32'h00000000;
    case (size)
      SZ_B: begin
        if (is_unsigned) begin
          data = {24'h000000, rot_s[7:0]};
        end else begin
          data = {{24{rot_s[7]}}, rot_s[7:0]};
        end
      end
      SZ_H: begin
        if (is_unsigned) begin
          data = {16'h0000, rot_s[15:0]};
        end else begin
          data = {{16{rot_s[15]}}, rot_s[15:0]};
        end
      end
      SZ_W:    data = rot_s;
      default: data = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator between the core MEM stage and the
// byte-lane data memory. One request at a time:
//   IDLE -> ACCESS -> RESP            (store)
//   IDLE -> ACCESS -> CAPTURE -> RESP (load, covers the 1-cycle read latency)
//   IDLE -> RESP                      (illegal size / disallowed misalignment)
// Ports:
//   clk, rst                   : clock, async active-high reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata : request fields
//   resp_valid/resp_ready      : response handshake
//   resp_rdata/resp_err        : extended load data (0 for stores/errors), error flag
//   mem_wea/en/addr/din        : registered memory command, active only in ACCESS
//   mem_dout                   : bank data, valid the cycle after an enabled read
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W           = 12,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_wea,
  output logic [3:0]        mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  state_e            state_r, state_s;
  logic              we_r, we_s;
  size_e             size_r, size_s;
  logic              uns_r, uns_s;
  logic [1:0]        off_r, off_s;

  logic              mem_wea_r, mem_wea_s;
  logic [3:0]        mem_en_r, mem_en_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [31:0]       mem_din_r, mem_din_s;
  logic              resp_valid_r, resp_valid_s;
  logic [31:0]       resp_rdata_r, resp_rdata_s;
  logic              resp_err_r, resp_err_s;

  size_e             req_sz_s;
  logic              req_bad_s;
  logic [31:0]       load_data_s;

  assign req_sz_s  = size_e'(req_size);
  assign req_bad_s = (req_sz_s == SZ_BAD) ||
                     (!ALLOW_MISALIGNED && is_misaligned(req_sz_s, req_addr[1:0]));

  lsu_load_align u_align (
    .mem_dout    (mem_dout),
    .off         (off_r),
    .size        (size_r),
    .is_unsigned (uns_r),
    .data        (load_data_s)
  );

  // Next-state and next register values; memory command is built straight
  // from the request at the accept edge so it is visible during ACCESS.
  always_comb begin
    state_s      = state_r;
    we_s         = we_r;
    size_s       = size_r;
    uns_s        = uns_r;
    off_s        = off_r;
    mem_wea_s    = 1'b0;
    mem_en_s     = 4'b0000;
    mem_addr_s   = {ADDR_W{1'b0}};
    mem_din_s    = 32'h00000000;
    resp_valid_s = resp_valid_r;
    resp_rdata_s = resp_rdata_r;
    resp_err_s   = resp_err_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          we_s         = req_we;
          size_s       = req_sz_s;
          uns_s        = req_unsigned;
          off_s        = req_addr[1:0];
          resp_rdata_s = 32'h00000000;
          if (req_bad_s) begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else begin
            state_s    = ACCESS;
            resp_err_s = 1'b0;
            mem_wea_s  = req_we;
            mem_en_s   = rotl4(base_mask(req_sz_s), req_addr[1:0]);
            mem_addr_s = req_addr;
            mem_din_s  = keep_bytes(req_wdata, req_sz_s);
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_r) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
        end else begin
          state_s = CAPTURE;
        end
      end
      CAPTURE: begin
        state_s      = RESP;
        resp_rdata_s = load_data_s;
        resp_valid_s = 1'b1;
      end
      RESP: begin
        if (resp_ready) begin
          state_s      = IDLE;
          resp_valid_s = 1'b0;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, latched request and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      size_r       <= SZ_B;
      uns_r        <= 1'b0;
      off_r        <= 2'b00;
      mem_wea_r    <= 1'b0;
      mem_en_r     <= 4'b0000;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_din_r    <= 32'h00000000;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h00000000;
      resp_err_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      we_r         <= we_s;
      size_r       <= size_s;
      uns_r        <= uns_s;
      off_r        <= off_s;
      mem_wea_r    <= mem_wea_s;
      mem_en_r     <= mem_en_s;
      mem_addr_r   <= mem_addr_s;
      mem_din_r    <= mem_din_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_err_r   <= resp_err_s;
    end
  end

  // Ready is held low for the whole time reset is asserted.
  assign req_ready  = (state_r == IDLE) && !rst;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;
  assign mem_wea    = mem_wea_r;
  assign mem_en     = mem_en_r;
  assign mem_addr   = mem_addr_r;
  assign mem_din    = mem_din_r;

endmodule
